// File: rtl/mem_dstb_nch.sv
// N-channel MEM-stage access distributor: decodes one load/store against
// base/mask windows, forwards it to the matching channel and returns its response.
module mem_dstb_nch #(
  parameter int                     NCH     = 2,
  parameter int                     ADDR_W  = 64,
  parameter int                     DATA_W  = 64,
  parameter logic [NCH*ADDR_W-1:0]  BASE    = '0,
  parameter logic [NCH*ADDR_W-1:0]  MASK    = '0,
  parameter int                     TIMEOUT = 255
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  up_valid_i,
  input  logic                  up_req_i,
  input  logic [ADDR_W-1:0]     up_addr_i,
  input  logic [1:0]            up_size_i,
  input  logic [DATA_W-1:0]     up_data_write_i,
  output logic                  up_ready_o,
  output logic [DATA_W-1:0]     up_data_read_o,
  output logic [1:0]            up_resp_o,
  output logic                  up_skip_o,
  output logic [NCH-1:0]        ch_valid_o,
  output logic                  ch_req_o,
  output logic [ADDR_W-1:0]     ch_addr_o,
  output logic [1:0]            ch_size_o,
  output logic [DATA_W-1:0]     ch_data_write_o,
  input  logic [NCH-1:0]        ch_ready_i,
  input  logic [NCH*DATA_W-1:0] ch_data_read_i,
  input  logic [NCH*2-1:0]      ch_resp_i
);

  localparam int          SEL_W    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t              state_r, state_s;
  logic                req_r;
  logic [ADDR_W-1:0]   addr_r;
  logic [1:0]          size_r;
  logic [DATA_W-1:0]   wdata_r;
  logic [SEL_W-1:0]    sel_r, sel_s;
  logic [15:0]         cnt_r, cnt_s;
  logic [NCH-1:0]      ch_valid_r, ch_valid_s;
  logic [DATA_W-1:0]   rdata_r, rdata_s;
  logic [1:0]          resp_r, resp_s;
  logic                ready_r;
  logic                skip_r, skip_s;
  logic                load_s;
  logic                hit_s;
  logic [SEL_W-1:0]    hit_sel_s;
  logic [NCH-1:0]      hit_onehot_s;

  // Window decode; scanning downward lets the lowest matching index win.
  always_comb begin
    hit_s        = 1'b0;
    hit_sel_s    = '0;
    hit_onehot_s = '0;
    for (int i = NCH - 1; i >= 0; i--) begin
      if ((up_addr_i & MASK[i*ADDR_W +: ADDR_W]) == BASE[i*ADDR_W +: ADDR_W]) begin
        hit_s           = 1'b1;
        hit_sel_s       = SEL_W'(i);
        hit_onehot_s    = '0;
        hit_onehot_s[i] = 1'b1;
      end else begin
        hit_s = hit_s;
      end
    end
  end

  // Next-state and completion data.
  always_comb begin
    state_s    = state_r;
    sel_s      = sel_r;
    cnt_s      = cnt_r;
    ch_valid_s = ch_valid_r;
    rdata_s    = rdata_r;
    resp_s     = resp_r;
    skip_s     = 1'b0;
    load_s     = 1'b0;
    case (state_r)
      IDLE: begin
        if (up_valid_i) begin
          load_s = 1'b1;
          if (hit_s) begin
            sel_s      = hit_sel_s;
            cnt_s      = 16'd0;
            ch_valid_s = hit_onehot_s;
            state_s    = BUSY;
          end else begin
            rdata_s = '0;
            resp_s  = 2'b11;
            skip_s  = 1'b1;
            state_s = DONE;
          end
        end else begin
          state_s = IDLE;
        end
      end
      BUSY: begin
        // Ready beats a coincident timeout.
        if (ch_ready_i[sel_r]) begin
          rdata_s    = ch_data_read_i[sel_r*DATA_W +: DATA_W];
          resp_s     = ch_resp_i[sel_r*2 +: 2];
          skip_s     = (sel_r != '0);
          ch_valid_s = '0;
          state_s    = DONE;
        end else if (cnt_r == CNT_LAST) begin
          rdata_s    = '0;
          resp_s     = 2'b10;
          skip_s     = (sel_r != '0);
          ch_valid_s = '0;
          state_s    = DONE;
        end else begin
          cnt_s = cnt_r + 16'd1;
        end
      end
      DONE: begin
        state_s = IDLE;
      end
      default: begin
        ch_valid_s = '0;
        state_s    = IDLE;
      end
    endcase
  end

  // State, latched request and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      req_r      <= 1'b0;
      addr_r     <= '0;
      size_r     <= 2'b00;
      wdata_r    <= '0;
      sel_r      <= '0;
      cnt_r      <= 16'd0;
      ch_valid_r <= '0;
      rdata_r    <= '0;
      resp_r     <= 2'b00;
      ready_r    <= 1'b0;
      skip_r     <= 1'b0;
    end else begin
      state_r    <= state_s;
      sel_r      <= sel_s;
      cnt_r      <= cnt_s;
      ch_valid_r <= ch_valid_s;
      rdata_r    <= rdata_s;
      resp_r     <= resp_s;
      ready_r    <= (state_s == DONE);
      skip_r     <= skip_s;
      if (load_s) begin
        req_r   <= up_req_i;
        addr_r  <= up_addr_i;
        size_r  <= up_size_i;
        wdata_r <= up_data_write_i;
      end else begin
        req_r   <= req_r;
        addr_r  <= addr_r;
        size_r  <= size_r;
        wdata_r <= wdata_r;
      end
    end
  end

  assign up_ready_o      = ready_r;
  assign up_data_read_o  = rdata_r;
  assign up_resp_o       = resp_r;
  assign up_skip_o       = skip_r;
  assign ch_valid_o      = ch_valid_r;
  assign ch_req_o        = req_r;
  assign ch_addr_o       = addr_r;
  assign ch_size_o       = size_r;
  assign ch_data_write_o = wdata_r;

endmodule

// File: tb/tb_mem_dstb_nch.sv
// Directed bench for mem_dstb_nch: three windows (memory, CLINT, a 4 KiB device),
// TIMEOUT of 8, hand-computed expectations.
module tb_mem_dstb_nch;

  localparam int NCH = 3;
  localparam int AW  = 64;
  localparam int DW  = 64;
  localparam logic [NCH*AW-1:0] TB_BASE = {64'h0000_0000_1000_0000,
                                           64'h0000_0000_0200_0000,
                                           64'h0000_0000_8000_0000};
  localparam logic [NCH*AW-1:0] TB_MASK = {64'hFFFF_FFFF_FFFF_F000,
                                           64'hFFFF_FFFF_FFFF_0000,
                                           64'hFFFF_FFFF_8000_0000};

  logic              clk = 1'b0;
  logic              rst;
  logic              up_valid_i;
  logic              up_req_i;
  logic [AW-1:0]     up_addr_i;
  logic [1:0]        up_size_i;
  logic [DW-1:0]     up_data_write_i;
  logic              up_ready_o;
  logic [DW-1:0]     up_data_read_o;
  logic [1:0]        up_resp_o;
  logic              up_skip_o;
  logic [NCH-1:0]    ch_valid_o;
  logic              ch_req_o;
  logic [AW-1:0]     ch_addr_o;
  logic [1:0]        ch_size_o;
  logic [DW-1:0]     ch_data_write_o;
  logic [NCH-1:0]    ch_ready_i;
  logic [NCH*DW-1:0] ch_data_read_i;
  logic [NCH*2-1:0]  ch_resp_i;

  int n_checks = 0;
  int n_fail   = 0;

  mem_dstb_nch #(
    .NCH(NCH), .ADDR_W(AW), .DATA_W(DW),
    .BASE(TB_BASE), .MASK(TB_MASK), .TIMEOUT(8)
  ) dut (
    .clk(clk), .rst(rst),
    .up_valid_i(up_valid_i), .up_req_i(up_req_i), .up_addr_i(up_addr_i),
    .up_size_i(up_size_i), .up_data_write_i(up_data_write_i),
    .up_ready_o(up_ready_o), .up_data_read_o(up_data_read_o),
    .up_resp_o(up_resp_o), .up_skip_o(up_skip_o),
    .ch_valid_o(ch_valid_o), .ch_req_o(ch_req_o), .ch_addr_o(ch_addr_o),
    .ch_size_o(ch_size_o), .ch_data_write_o(ch_data_write_o),
    .ch_ready_i(ch_ready_i), .ch_data_read_i(ch_data_read_i), .ch_resp_i(ch_resp_i)
  );

  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic wr, input logic [63:0] addr, input logic [1:0] size,
                       input logic [63:0] wdata);
    up_valid_i      = 1'b1;
    up_req_i        = wr;
    up_addr_i       = addr;
    up_size_i       = size;
    up_data_write_i = wdata;
  endtask

  task automatic idle_bus();
    up_valid_i = 1'b0;
    ch_ready_i = 3'b000;
  endtask

  initial begin
    int vcnt;
    int lat;
    rst = 1'b1;
    up_valid_i = 1'b0; up_req_i = 1'b0; up_addr_i = '0; up_size_i = 2'd0;
    up_data_write_i = '0; ch_ready_i = '0; ch_data_read_i = '0; ch_resp_i = '0;
    tick(); tick();
    rst = 1'b0;
    check_val("rst_valid", 64'(ch_valid_o), 64'h0);
    check_val("rst_ready", 64'(up_ready_o), 64'h0);
    check_val("rst_skip",  64'(up_skip_o), 64'h0);
    check_val("rst_resp",  64'(up_resp_o), 64'h0);
    check_val("rst_data",  up_data_read_o, 64'h0);
    check_val("rst_addr",  ch_addr_o, 64'h0);

    // Read from main memory, ready on the 3rd BUSY cycle.
    issue(1'b0, 64'h8000_04C0, 2'd3, 64'h0);
    tick();
    check_val("s1_valid0", 64'(ch_valid_o), 64'h1);
    check_val("s1_addr",   ch_addr_o, 64'h8000_04C0);
    check_val("s1_size",   64'(ch_size_o), 64'h3);
    check_val("s1_req",    64'(ch_req_o), 64'h0);
    tick();
    check_val("s1_valid1", 64'(ch_valid_o), 64'h1);
    check_val("s1_noready", 64'(up_ready_o), 64'h0);
    tick();
    check_val("s1_valid2", 64'(ch_valid_o), 64'h1);
    ch_ready_i = 3'b001;
    ch_data_read_i[0 +: 64] = 64'h1122_3344_5566_7788;
    ch_resp_i[1:0] = 2'b00;
    tick();
    check_val("s1_ready", 64'(up_ready_o), 64'h1);
    check_val("s1_data",  up_data_read_o, 64'h1122_3344_5566_7788);
    check_val("s1_resp",  64'(up_resp_o), 64'h0);
    check_val("s1_skip",  64'(up_skip_o), 64'h0);
    check_val("s1_vdrop", 64'(ch_valid_o), 64'h0);
    idle_bus();
    tick();
    check_val("s1_pulse", 64'(up_ready_o), 64'h0);
    check_val("s1_hold",  up_data_read_o, 64'h1122_3344_5566_7788);

    // ch2 never answers: timeout after 8 BUSY cycles.
    issue(1'b0, 64'h1000_0010, 2'd2, 64'h0);
    tick();
    idle_bus();
    vcnt = 0;
    lat  = 0;
    while (up_ready_o !== 1'b1 && lat < 20) begin
      if (ch_valid_o === 3'b100) vcnt++;
      lat++;
      tick();
    end
    check_val("s4_vcycles", 64'(vcnt), 64'd8);
    check_val("s4_latency", 64'(lat), 64'd8);
    check_val("s4_resp",    64'(up_resp_o), 64'h2);
    check_val("s4_data",    up_data_read_o, 64'h0);
    check_val("s4_vdrop",   64'(ch_valid_o), 64'h0);
    tick();

    // Store to mtimecmp on the CLINT channel.
    issue(1'b1, 64'h0200_4000, 2'd3, 64'h5);
    tick();
    check_val("s2_valid", 64'(ch_valid_o), 64'h2);
    check_val("s2_wdata", ch_data_write_o, 64'h5);
    check_val("s2_req",   64'(ch_req_o), 64'h1);
    ch_ready_i = 3'b010;
    ch_data_read_i[64 +: 64] = 64'hAAAA;
    ch_resp_i[3:2] = 2'b00;
    tick();
    check_val("s2_ready", 64'(up_ready_o), 64'h1);
    check_val("s2_skip",  64'(up_skip_o), 64'h1);
    check_val("s2_resp",  64'(up_resp_o), 64'h0);
    idle_bus();
    tick();
    check_val("s2_skipoff", 64'(up_skip_o), 64'h0);

    // Unmapped address: DECERR one cycle after acceptance.
    issue(1'b0, 64'h3000_0000, 2'd3, 64'h0);
    tick();
    check_val("s3_ready", 64'(up_ready_o), 64'h1);
    check_val("s3_resp",  64'(up_resp_o), 64'h3);
    check_val("s3_data",  up_data_read_o, 64'h0);
    check_val("s3_skip",  64'(up_skip_o), 64'h1);
    check_val("s3_valid", 64'(ch_valid_o), 64'h0);
    idle_bus();
    tick();

    // ch0 ready on the final counter cycle plus a stray ch1 ready.
    issue(1'b0, 64'h8000_0100, 2'd3, 64'h0);
    tick();
    check_val("s5_valid", 64'(ch_valid_o), 64'h1);
    repeat (7) tick();
    check_val("s5_waiting", 64'(up_ready_o), 64'h0);
    ch_ready_i = 3'b011;
    ch_data_read_i[0 +: 64]  = 64'hCAFE_F00D_1234_5678;
    ch_data_read_i[64 +: 64] = 64'hBAD0_BAD0_BAD0_BAD0;
    ch_resp_i = 6'b00_11_00;
    tick();
    check_val("s5_ready", 64'(up_ready_o), 64'h1);
    check_val("s5_data",  up_data_read_o, 64'hCAFE_F00D_1234_5678);
    check_val("s5_resp",  64'(up_resp_o), 64'h0);
    check_val("s5_skip",  64'(up_skip_o), 64'h0);
    idle_bus();
    tick();

    // Reset during BUSY drops the access.
    issue(1'b0, 64'h8000_0000, 2'd3, 64'h0);
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    idle_bus();
    check_val("s6_vdrop",   64'(ch_valid_o), 64'h0);
    check_val("s6_noready", 64'(up_ready_o), 64'h0);
    check_val("s6_data",    up_data_read_o, 64'h0);
    ch_ready_i = 3'b001;
    tick();
    check_val("s6_stray", 64'(up_ready_o), 64'h0);
    ch_ready_i = 3'b000;
    tick();
    check_val("s6_idle", 64'(up_ready_o), 64'h0);
    issue(1'b0, 64'h0200_0008, 2'd2, 64'h0);
    tick();
    check_val("s6_valid2", 64'(ch_valid_o), 64'h2);
    ch_ready_i = 3'b010;
    ch_data_read_i[64 +: 64] = 64'h77;
    ch_resp_i = 6'b00_10_00;
    tick();
    check_val("s6_ready2", 64'(up_ready_o), 64'h1);
    check_val("s6_data2",  up_data_read_o, 64'h77);
    check_val("s6_resp2",  64'(up_resp_o), 64'h2);
    check_val("s6_skip2",  64'(up_skip_o), 64'h1);
    idle_bus();
    tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_dstb_nch.md
# mem_dstb_nch

Parametrised N-channel memory-access distributor for the MEM stage. It is the successor to the fixed two-way memory/CLINT distributor. It accepts one load/store request from the MEM-stage bus interface, decodes the address against NCH programmable base/mask windows, and forwards the request to the matching downstream channel. It returns that channel's data and response, generates decode-error and timeout error responses, and flags non-memory accesses for difftest skipping.

## Interface
Parameters:
- NCH, 2: number of downstream channels (1..8); channel 0 is main memory.
- ADDR_W, 64: address width.
- DATA_W, 64: data width.
- BASE, {NCH{ADDR_W'h0}}: flattened window bases; channel i occupies bits [i*ADDR_W +: ADDR_W].
- MASK, {NCH{ADDR_W'h0}}: flattened window masks, same packing.
- TIMEOUT, 255: maximum BUSY cycles without channel ready (2..65535).

Ports:
- clk  in  1  clock.
- rst  in  1  reset; synchronous, active-high.
- up_valid_i  in  1  upstream request valid.
- up_req_i  in  1  1 = write, 0 = read.
- up_addr_i  in  ADDR_W  access address.
- up_size_i  in  2  0=byte, 1=half, 2=word, 3=dword.
- up_data_write_i  in  DATA_W  store data.
- up_ready_o  out  1  one-cycle completion pulse.
- up_data_read_o  out  DATA_W  load data, valid with up_ready_o.
- up_resp_o  out  2  00 OKAY, 10 SLVERR (timeout or channel), 11 DECERR.
- up_skip_o  out  1  pulses with up_ready_o when the serving channel != 0.
- ch_valid_o  out  NCH  per-channel request valid.
- ch_req_o, ch_addr_o, ch_size_o, ch_data_write_o  out  1/ADDR_W/2/DATA_W  latched request, broadcast to all channels.
- ch_ready_i  in  NCH  per-channel completion.
- ch_data_read_i  in  NCH*DATA_W  per-channel read data, flattened.
- ch_resp_i  in  NCH*2  per-channel response, flattened.

## Operation
- States: IDLE, BUSY, DONE.
- IDLE, up_valid_i=1:
  - Latch req/addr/size/data.
  - Decode: channel i hits when (addr & MASK_i) == BASE_i. The lowest matching index wins.
  - On a hit: store sel = i, clear the timeout counter, go to BUSY.
  - On no hit: set resp=11, read data = 0, go to DONE.
- BUSY:
  - ch_valid_o[sel] = 1; all other ch_valid_o bits = 0.
  - When ch_ready_i[sel] = 1: latch ch_data_read_i[sel] and ch_resp_i[sel], go to DONE.
  - Otherwise the counter increments. If the counter equals TIMEOUT-1 without ready: resp=10, data=0, go to DONE.
  - If ready and the timeout occur in the same cycle, ready wins.
  - ch_ready_i bits of unselected channels are ignored in every state.
- DONE:
  - up_ready_o=1 for exactly one cycle.
  - up_data_read_o and up_resp_o hold the latched values.
  - up_skip_o = (sel != 0) for a completed access. For DECERR, up_skip_o = 1.
  - Next state is always IDLE.
- up_data_read_o and up_resp_o hold their last value until the next DONE. up_ready_o and up_skip_o are 0 outside DONE.
- Read data is passed through unshifted. Byte-lane alignment belongs to the upstream interface.
- The broadcast ch_* request fields are stable for the whole of BUSY.

## Timing
- Reset state:
  - State = IDLE.
  - ch_valid_o, up_ready_o, up_skip_o = 0.
  - up_resp_o = 00; up_data_read_o = 0; latched request fields = 0; counter = 0.
- Reset asserted mid-transaction:
  - The in-flight access is dropped and no up_ready_o is issued.
  - ch_valid_o falls in the cycle after the reset edge.
- Mapped access:
  - Accept at edge E0; ch_valid_o[sel] is high from E0 onward.
  - ch_ready_i[sel] is sampled at edge Ek; ch_valid_o[sel] drops after Ek.
  - up_ready_o is high during cycle Ek..Ek+1.
  - Minimum request-to-completion latency is 2 cycles (ready in the first BUSY cycle).
- Unmapped access: up_ready_o is high the cycle after acceptance (latency 1).
- Timeout: up_ready_o is asserted TIMEOUT+1 cycles after acceptance.
- Upstream handshake:
  - The master holds up_valid_i and the request fields stable until up_ready_o.
  - up_valid_i still high in the cycle after up_ready_o is taken as a new request.
- Downstream handshake: a channel asserts ready for one cycle per request and must not assert it while its valid is low.

## Test plan
All scenarios use NCH=3 with these windows:
- ch0: BASE 0x8000_0000, MASK 0xFFFF_FFFF_8000_0000.
- ch1: BASE 0x0200_0000, MASK 0xFFFF_FFFF_FFFF_0000.
- ch2: BASE 0x1000_0000, MASK 0xFFFF_FFFF_FFFF_F000.

Scenarios:
- Read from 0x8000_04C0, size 3; ch0 returns 0x1122_3344_5566_7788 with resp 00 on its 3rd BUSY cycle -> ch_valid_o = 001 for 3 cycles; up_ready_o one cycle later; data 0x1122_3344_5566_7788, resp 00, up_skip_o = 0.
- Write 0x5 to 0x0200_4000 (mtimecmp) -> only ch_valid_o[1] asserted; ch_data_write_o = 0x5; completion with up_skip_o = 1, resp 00.
- Read from 0x3000_0000 -> no ch_valid_o activity; up_ready_o the cycle after acceptance; resp 11, data 0, up_skip_o = 1.
- ch2 never responds, TIMEOUT=8 -> ch_valid_o[2] high 8 cycles then drops; up_ready_o with resp 10, data 0.
- ch0 ready arrives on the counter's final cycle, together with a stray ch_ready_i[1] -> ready wins; resp = ch0 response; the stray ready is ignored.
- rst pulsed during BUSY of a ch0 access; ch0 ready arrives afterwards -> no up_ready_o; ch_valid_o = 0 after the reset edge; next request is served normally.
